// File: rtl/pipeline_ctrl.sv
// Pipeline staging and control: DEPTH-stage payload shift register with stall,
// flush, load-use bubble insertion, forwarding selects and perf counters.
module pipeline_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int CW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [AW-1:0]          in_dest,
  input  logic                   in_wr,
  input  logic                   in_load,
  input  logic [AW-1:0]          in_src_a,
  input  logic [AW-1:0]          in_src_b,
  input  logic                   stall_in,
  input  logic                   flush,
  output logic                   in_ready,
  output logic                   load_use_stall,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH*AW-1:0]    stage_dest,
  output logic [3:0]             fwd_a_sel,
  output logic [3:0]             fwd_b_sel,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [CW-1:0]          retire_cnt,
  output logic [CW-1:0]          bubble_cnt
);

  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0]            wr;
  logic                        ld0;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [DEPTH-1:0][AW-1:0]    dst;
  logic                        hazard;

  assign hazard = vld_pipe[0] & ld0 & wr[0] & (dst[0] != '0) & in_valid &
                  ((dst[0] == in_src_a) | (dst[0] == in_src_b));
  assign load_use_stall = hazard & ~flush & ~stall_in;
  assign in_ready       = ~reset & ~stall_in & (flush | ~hazard);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      wr       <= '0;
      ld0      <= 1'b0;
      dat      <= '0;
      dst      <= '0;
    end else begin
      // Stage 0: a flush kills it even under stall; a hazard turns it into a bubble.
      if (flush) begin
        vld_pipe[0] <= 1'b0;
        wr[0]       <= 1'b0;
        ld0         <= 1'b0;
      end else if (!stall_in) begin
        vld_pipe[0] <= in_valid & ~hazard;
        wr[0]       <= in_valid & in_wr & ~hazard;
        ld0         <= in_valid & in_load & ~hazard;
        dat[0]      <= in_data;
        dst[0]      <= in_dest;
      end
      // Older stages move whenever not stalled; the flushed stage-0 slot travels as a bubble.
      if (!stall_in) begin
        for (int k = 1; k < DEPTH; k++) begin
          vld_pipe[k] <= (k == 1) ? (vld_pipe[0] & ~flush) : vld_pipe[k-1];
          wr[k]       <= (k == 1) ? (wr[0] & ~flush)       : wr[k-1];
          dat[k]      <= dat[k-1];
          dst[k]      <= dst[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (vld_pipe[DEPTH-1] && !stall_in) retire_cnt <= retire_cnt + 1'b1;
      if (load_use_stall)                 bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  function automatic logic [3:0] fwd_sel(input logic [AW-1:0] src);
    logic [3:0] sel;
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (vld_pipe[k] && wr[k] && (dst[k] != '0) && (dst[k] == src) && !(k == 0 && ld0))
        sel = 4'(k + 1);
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_sel = fwd_sel(in_src_a);
    fwd_b_sel = fwd_sel(in_src_b);
  end

  assign stage_valid = vld_pipe;
  assign stage_data  = dat;
  assign stage_dest  = dst;
  assign out_valid   = vld_pipe[DEPTH-1];
  assign out_data    = dat[DEPTH-1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (DEPTH=3, CW=4 so the wrap case is reachable).
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_dest = '0;
  logic        in_wr = 1'b0;
  logic        in_load = 1'b0;
  logic [4:0]  in_src_a = '0;
  logic [4:0]  in_src_b = '0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic        in_ready, load_use_stall, out_valid;
  logic [2:0]  stage_valid;
  logic [95:0] stage_data;
  logic [14:0] stage_dest;
  logic [3:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] out_data;
  logic [3:0]  retire_cnt, bubble_cnt;
  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.WIDTH(32), .DEPTH(3), .AW(5), .CW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_dest(in_dest), .in_wr(in_wr), .in_load(in_load), .in_src_a(in_src_a),
    .in_src_b(in_src_b), .stall_in(stall_in), .flush(flush), .in_ready(in_ready),
    .load_use_stall(load_use_stall), .stage_valid(stage_valid), .stage_data(stage_data),
    .stage_dest(stage_dest), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .out_valid(out_valid), .out_data(out_data), .retire_cnt(retire_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic [4:0] dst,
                        input logic w, input logic ld, input logic [4:0] sa, input logic [4:0] sb);
    in_valid = v; in_data = d; in_dest = dst; in_wr = w; in_load = ld;
    in_src_a = sa; in_src_b = sb;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b1, 32'h55, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0);
    tick(); tick();
    checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", stage_valid); end
    checks++; if (retire_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", retire_cnt, bubble_cnt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", in_ready); end
    checks++; if (fwd_a_sel !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_out got fwd %0d ov %b exp 0 0", fwd_a_sel, out_valid); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h100 + i, 5'(i + 1), 1'b1, 1'b0, 5'd0, 5'd0);
      tick();
      checks++;
      if (out_valid !== (i >= 2)) begin errors++; $display("FAIL b2b_ov%0d got %b exp %b", i, out_valid, (i >= 2)); end
    end
    checks++; if (out_data !== 32'h101 || retire_cnt !== 4'd1) begin errors++; $display("FAIL b2b_data got %h/%0d exp 101/1", out_data, retire_cnt); end
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick(); tick(); tick();
    checks++; if (retire_cnt !== 4'd4 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_retire got %0d ov %b exp 4 0", retire_cnt, out_valid); end
  endtask

  task automatic test_load_use();
    set_in(1'b1, 32'hAA, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 32'h66, 5'd6, 1'b1, 1'b0, 5'd5, 5'd1);
    #1;
    checks++; if (load_use_stall !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL lu_detect got stall %b ready %b exp 1 0", load_use_stall, in_ready); end
    checks++; if (fwd_a_sel !== 4'd0) begin errors++; $display("FAIL lu_nofwd got %0d exp 0", fwd_a_sel); end
    tick();
    checks++; if (bubble_cnt !== 4'd1 || stage_valid !== 3'b010) begin errors++; $display("FAIL lu_bubble got %0d %b exp 1 010", bubble_cnt, stage_valid); end
    checks++; if (load_use_stall !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lu_clear got stall %b ready %b exp 0 1", load_use_stall, in_ready); end
    checks++; if (fwd_a_sel !== 4'd2 || fwd_b_sel !== 4'd0) begin errors++; $display("FAIL lu_fwd got %0d/%0d exp 2/0", fwd_a_sel, fwd_b_sel); end
    tick();
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++; if (stage_valid !== 3'b101 || stage_data[31:0] !== 32'h66 || bubble_cnt !== 4'd1) begin errors++; $display("FAIL lu_enter got %b %h %0d exp 101 66 1", stage_valid, stage_data[31:0], bubble_cnt); end
    tick(); tick(); tick();
    checks++; if (retire_cnt !== 4'd6) begin errors++; $display("FAIL lu_retire got %0d exp 6", retire_cnt); end
  endtask

  task automatic test_fwd_priority();
    set_in(1'b1, 32'h00, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
    set_in(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0); tick();
    set_in(1'b1, 32'h44, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0); tick();
    set_in(1'b0, 32'h77, 5'd7, 1'b1, 1'b0, 5'd3, 5'd3);
    #1;
    checks++; if (fwd_a_sel !== 4'd1 || fwd_b_sel !== 4'd1) begin errors++; $display("FAIL fwd_young got %0d/%0d exp 1/1", fwd_a_sel, fwd_b_sel); end
    in_src_a = 5'd0;
    #1;
    checks++; if (fwd_a_sel !== 4'd0 || fwd_b_sel !== 4'd1) begin errors++; $display("FAIL fwd_r0 got %0d/%0d exp 0/1", fwd_a_sel, fwd_b_sel); end
    tick(); tick(); tick(); tick();
    checks++; if (retire_cnt !== 4'd9) begin errors++; $display("FAIL fwd_retire got %0d exp 9", retire_cnt); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'hD0 + i, 5'(10 + i), 1'b1, 1'b0, 5'd0, 5'd0);
      tick();
    end
    stall_in = 1'b1;
    set_in(1'b1, 32'hD3, 5'd13, 1'b1, 1'b0, 5'd0, 5'd0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (stage_data !== {32'hD0, 32'hD1, 32'hD2} || retire_cnt !== 4'd9 || stage_valid !== 3'b111) begin
        errors++; $display("FAIL stall_hold%0d got %h %0d %b exp D0_D1_D2 9 111", i, stage_data, retire_cnt, stage_valid);
      end
    end
    stall_in = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", in_ready); end
    tick();
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++; if (stage_data !== {32'hD1, 32'hD2, 32'hD3} || retire_cnt !== 4'd10) begin errors++; $display("FAIL stall_resume got %h %0d exp D1_D2_D3 10", stage_data, retire_cnt); end
    tick();
    checks++; if (out_data !== 32'hD2 || retire_cnt !== 4'd11) begin errors++; $display("FAIL stall_d2 got %h %0d exp D2 11", out_data, retire_cnt); end
    tick();
    checks++; if (out_data !== 32'hD3 || retire_cnt !== 4'd12) begin errors++; $display("FAIL stall_d3 got %h %0d exp D3 12", out_data, retire_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0 || retire_cnt !== 4'd13) begin errors++; $display("FAIL stall_drain got %b %0d exp 0 13", out_valid, retire_cnt); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'hF0 + i, 5'(20 + i), 1'b1, 1'b0, 5'd0, 5'd0);
      tick();
    end
    set_in(1'b1, 32'hF3, 5'd23, 1'b1, 1'b0, 5'd0, 5'd0);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++; if (stage_valid !== 3'b100 || out_data !== 32'hF1 || retire_cnt !== 4'd14) begin errors++; $display("FAIL flush_kill got %b %h %0d exp 100 F1 14", stage_valid, out_data, retire_cnt); end
    tick();
    checks++; if (stage_valid !== 3'b000 || retire_cnt !== 4'd15) begin errors++; $display("FAIL flush_excl got %b %0d exp 000 15", stage_valid, retire_cnt); end
    set_in(1'b1, 32'h88, 5'd8, 1'b1, 1'b1, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 32'h99, 5'd9, 1'b1, 1'b0, 5'd8, 5'd8);
    flush = 1'b1;
    #1;
    checks++; if (load_use_stall !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_lu got stall %b ready %b exp 0 1", load_use_stall, in_ready); end
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    checks++; if (bubble_cnt !== 4'd1 || stage_valid !== 3'b000) begin errors++; $display("FAIL flush_lu_cnt got %0d %b exp 1 000", bubble_cnt, stage_valid); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'hC0 + i, 5'(24 + i), 1'b1, 1'b0, 5'd0, 5'd0);
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got %b exp 1", out_valid); end
    reset = 1'b1;
    tick();
    checks++; if (stage_valid !== 3'b000 || retire_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin errors++; $display("FAIL mid_reset got %b %0d %0d exp 000 0 0", stage_valid, retire_cnt, bubble_cnt); end
    reset = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 32'h200 + i, 5'd30, 1'b1, 1'b0, 5'd0, 5'd0);
      tick();
    end
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick(); tick(); tick();
    checks++; if (retire_cnt !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap got %0d %b exp 1 0", retire_cnt, out_valid); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_stall();
    test_flush();
    test_mid_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
